// File: rtl/nrs_gen_pingpong_rx_if.sv
// Bus bundle between the NRS generator and the channel estimator:
// frame control, bank handshake and the per-port QPSK read ports.
interface nrs_gen_pingpong_rx_if #(
    parameter int WIDTH_B = 9,
    parameter int NUM_RD  = 2,
    parameter int AW      = 2
);
    logic                   new_frame;
    logic [WIDTH_B-1:0]     N_cell_ID;
    logic                   est_ack;
    logic [NUM_RD*AW-1:0]   rd_addr;
    logic [NUM_RD-1:0]      nrs_r;
    logic [NUM_RD-1:0]      nrs_i;
    logic                   nrs_ready;
    logic [4:0]             nrs_slot;
    logic                   busy;

    // Estimator side: drives frame control, ack and read addresses.
    modport master (
        output new_frame, N_cell_ID, est_ack, rd_addr,
        input  nrs_r, nrs_i, nrs_ready, nrs_slot, busy
    );

    // Generator side.
    modport slave (
        input  new_frame, N_cell_ID, est_ack, rd_addr,
        output nrs_r, nrs_i, nrs_ready, nrs_slot, busy
    );
endinterface

// File: rtl/nrs_gen_pingpong_rx.sv
// NB-IoT RX NRS generator. Per NRS symbol: serial cinit multiply, LFSR load,
// Gold fast-forward, then capture of BITS_PER_SYM c(n) bits into the write bank.
// When a slot is complete the write bank becomes the readable bank (ping-pong),
// so the estimator reads slot k while slot k+1 is being generated.
module nrs_gen_pingpong_rx #(
    parameter int WIDTH_B      = 9,
    parameter int NUM_RD       = 2,
    parameter int N_SYM        = 2,
    parameter int L_FIRST      = 5,
    parameter int BITS_PER_SYM = 4,
    parameter int SEQ_OFFSET   = 218,
    parameter int NC           = 1600,
    parameter int SLOTS        = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    nrs_gen_pingpong_rx_if.slave   bus
);

    localparam int DEPTH    = N_SYM * BITS_PER_SYM / 2;
    localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TOTAL    = N_SYM * BITS_PER_SYM;
    localparam int BW       = $clog2(TOTAL);
    localparam int SKIP_LEN = NC + SEQ_OFFSET;
    localparam int SKW      = $clog2(SKIP_LEN + 1);
    localparam int SW       = (N_SYM > 1) ? $clog2(N_SYM) : 1;
    localparam int JW       = $clog2(BITS_PER_SYM);
    localparam int MW       = WIDTH_B + 1;
    localparam int PW       = 8 + MW;
    localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE, MULT, LOAD, SKIP, CAPTURE, SWAP, WAIT_SWAP
    } state_t;

    state_t               state, next_state;
    logic [4:0]           slot;
    logic [SW-1:0]        sym;
    logic [2:0]           mult_cnt;
    logic [SKW-1:0]       skip_cnt;
    logic [JW-1:0]        cap_cnt;
    logic                 wr_sel;
    logic                 rd_valid;
    logic [4:0]           out_slot;
    logic [30:0]          x1, x2;
    logic [WIDTH_B-1:0]   cell_id;
    logic [PW-1:0]        acc;
    logic [1:0][TOTAL-1:0] bank;
    logic [NUM_RD-1:0]    rd_r, rd_i;

    logic [7:0]           mult_a;
    logic [MW-1:0]        mult_b;
    logic [PW-1:0]        partial;
    logic [30:0]          cinit;
    logic [BW-1:0]        wr_idx;
    logic                 rd_sel;
    logic                 swap_ok;
    logic                 do_swap;
    logic                 cap_last;
    logic                 sym_last;

    // A = 7*(slot+1) + l + 1 with l = L_FIRST + sym; multiplier is 2*N_cell_ID+1.
    assign mult_a   = 8'd7 * ({3'b000, slot} + 8'd1) + 8'(L_FIRST + 1) + 8'(sym);
    assign mult_b   = {cell_id, 1'b1};
    assign partial  = mult_a[mult_cnt] ? (PW'(mult_b) << mult_cnt) : '0;
    assign cinit    = 31'({acc, 10'b0}) + 31'(mult_b);
    assign wr_idx   = BW'(sym) * BW'(BITS_PER_SYM) + BW'(cap_cnt);
    assign rd_sel   = ~wr_sel;
    assign cap_last = (cap_cnt == JW'(BITS_PER_SYM - 1));
    assign sym_last = (sym == SW'(N_SYM - 1));
    // A swap may proceed once the estimator has released (or never had) the readable bank.
    assign swap_ok  = !rd_valid || bus.est_ack;

    assign bus.nrs_r     = rd_r;
    assign bus.nrs_i     = rd_i;
    assign bus.nrs_ready = rd_valid;
    assign bus.nrs_slot  = out_slot;
    assign bus.busy      = (state != IDLE) && (state != WAIT_SWAP);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; new_frame aborts whatever is in progress.
    always_comb begin
        next_state = state;
        do_swap    = 1'b0;
        case (state)
            IDLE:      next_state = IDLE;
            MULT:      if (mult_cnt == 3'd7) next_state = LOAD;
            LOAD:      next_state = SKIP;
            SKIP:      if (skip_cnt == SKW'(SKIP_LEN - 1)) next_state = CAPTURE;
            CAPTURE:   if (cap_last) next_state = sym_last ? SWAP : MULT;
            SWAP, WAIT_SWAP: begin
                if (swap_ok) begin
                    next_state = MULT;
                    do_swap    = 1'b1;
                end else begin
                    next_state = WAIT_SWAP;
                end
            end
            default:   next_state = IDLE;
        endcase
        if (bus.new_frame) begin
            next_state = MULT;
            do_swap    = 1'b0;
        end
    end

    // Sequencing counters, slot tracking and bank ownership.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot     <= '0;
            sym      <= '0;
            mult_cnt <= '0;
            skip_cnt <= '0;
            cap_cnt  <= '0;
            wr_sel   <= 1'b0;
            rd_valid <= 1'b0;
            out_slot <= '0;
        end else if (bus.new_frame) begin
            slot     <= '0;
            sym      <= '0;
            mult_cnt <= '0;
            skip_cnt <= '0;
            cap_cnt  <= '0;
            rd_valid <= 1'b0;
        end else begin
            mult_cnt <= (state == MULT) ? mult_cnt + 3'd1 : 3'd0;
            skip_cnt <= (state == SKIP) ? skip_cnt + SKW'(1) : '0;
            cap_cnt  <= (state == CAPTURE && !cap_last) ? cap_cnt + JW'(1) : '0;
            if (state == CAPTURE && cap_last && !sym_last) begin
                sym <= sym + SW'(1);
            end
            if (do_swap) begin
                wr_sel   <= ~wr_sel;
                rd_valid <= 1'b1;
                out_slot <= slot;
                slot     <= (slot == 5'(SLOTS - 1)) ? 5'd0 : slot + 5'd1;
                sym      <= '0;
            end else if (bus.est_ack && rd_valid) begin
                rd_valid <= 1'b0;
            end
        end
    end

    // Gold LFSR pair: load at LOAD, shift right once per SKIP/CAPTURE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x1 <= '0;
            x2 <= '0;
        end else if (state == LOAD) begin
            x1 <= 31'h1;
            x2 <= cinit;
        end else if (state == SKIP || state == CAPTURE) begin
            x1 <= {x1[3] ^ x1[0], x1[30:1]};
            x2 <= {x2[3] ^ x2[2] ^ x2[1] ^ x2[0], x2[30:1]};
        end
    end

    // Cell ID latch, shift-add product accumulator and write-bank capture.
    always_ff @(posedge clk) begin
        if (bus.new_frame) begin
            cell_id <= bus.N_cell_ID;
        end
        if (state == MULT) begin
            acc <= ((mult_cnt == 3'd0) ? '0 : acc) + partial;
        end
        if (state == CAPTURE) begin
            bank[wr_sel][wr_idx] <= x1[0] ^ x2[0];
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0] addr;
        logic          r_q, i_q;
        assign addr    = bus.rd_addr[p*AW +: AW];
        assign rd_r[p] = r_q;
        assign rd_i[p] = i_q;

        // Registered read of entry addr from the readable bank; out-of-range reads give 0.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_q <= 1'b0;
                i_q <= 1'b0;
            end else if ({1'b0, addr} < DEPTH_V) begin
                r_q <= bank[rd_sel][{addr, 1'b0}];
                i_q <= bank[rd_sel][{addr, 1'b1}];
            end else begin
                r_q <= 1'b0;
                i_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nrs_gen_pingpong_rx.sv
// Testbench for nrs_gen_pingpong_rx: default-parameter instance (A) and a
// shortened-sequence instance (B, 6 bits/symbol so out-of-range addresses exist).
module tb_nrs_gen_pingpong_rx;

    localparam int N_SYM   = 2;
    localparam int L_FIRST = 5;
    localparam int A_BPS = 4, A_SEQ = 218, A_NC = 1600;
    localparam int B_BPS = 6, B_SEQ = 10,  B_NC = 40;
    localparam int A_LAT = N_SYM * (8 + 1 + A_NC + A_SEQ + A_BPS) + 1;
    localparam int B_LAT = N_SYM * (8 + 1 + B_NC + B_SEQ + B_BPS) + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nrs_gen_pingpong_rx_if #(.WIDTH_B(9), .NUM_RD(2), .AW(2)) ifa ();
    nrs_gen_pingpong_rx_if #(.WIDTH_B(9), .NUM_RD(2), .AW(3)) ifb ();

    nrs_gen_pingpong_rx dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    nrs_gen_pingpong_rx #(.BITS_PER_SYM(B_BPS), .SEQ_OFFSET(B_SEQ), .NC(B_NC))
        dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int         dut;
        int         a0;
        int         a1;
        logic [1:0] r;
        logic [1:0] i;
    } rd_item_t;
    rd_item_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // cinit from its defining formula.
    function automatic longint cinit_of(input int n_id, input int slot, input int l);
        longint a, m;
        a = 7 * (slot + 1) + l + 1;
        m = 2 * n_id + 1;
        return a * m * 1024 + m;
    endfunction

    // Gold sequence via the x1/x2 recurrences; returns bank image, bit s*bps+j = c(seqoff+j) of symbol s.
    function automatic logic [63:0] exp_bank(input int n_id, input int slot, input int bps,
                                             input int seqoff, input int nc);
        logic [63:0] res;
        bit x1 [0:4095];
        bit x2 [0:4095];
        longint ci;
        int len;
        res = '0;
        len = nc + seqoff + bps;
        for (int s = 0; s < N_SYM; s++) begin
            ci = cinit_of(n_id, slot, L_FIRST + s);
            for (int k = 0; k < 31; k++) begin
                x1[k] = (k == 0);
                x2[k] = ((ci >> k) & 1) != 0;
            end
            for (int n = 0; n + 31 < len; n++) begin
                x1[n+31] = x1[n+3] ^ x1[n];
                x2[n+31] = x2[n+3] ^ x2[n+2] ^ x2[n+1] ^ x2[n];
            end
            for (int j = 0; j < bps; j++) begin
                res[s*bps + j] = x1[nc+seqoff+j] ^ x2[nc+seqoff+j];
            end
        end
        return res;
    endfunction

    function automatic logic get_ready(input int d);
        return (d == 0) ? ifa.nrs_ready : ifb.nrs_ready;
    endfunction
    function automatic logic [4:0] get_slot(input int d);
        return (d == 0) ? ifa.nrs_slot : ifb.nrs_slot;
    endfunction
    function automatic logic get_busy(input int d);
        return (d == 0) ? ifa.busy : ifb.busy;
    endfunction
    function automatic logic [1:0] get_r(input int d);
        return (d == 0) ? ifa.nrs_r : ifb.nrs_r;
    endfunction
    function automatic logic [1:0] get_i(input int d);
        return (d == 0) ? ifa.nrs_i : ifb.nrs_i;
    endfunction

    task automatic pulse_nf(input int d, input int n_id);
        if (d == 0) begin ifa.N_cell_ID = 9'(n_id); ifa.new_frame = 1'b1; end
        else        begin ifb.N_cell_ID = 9'(n_id); ifb.new_frame = 1'b1; end
        @(negedge clk);
        ifa.new_frame = 1'b0;
        ifb.new_frame = 1'b0;
    endtask

    task automatic pulse_ack(input int d);
        if (d == 0) ifa.est_ack = 1'b1; else ifb.est_ack = 1'b1;
        @(negedge clk);
        ifa.est_ack = 1'b0;
        ifb.est_ack = 1'b0;
    endtask

    task automatic wait_ready(input int d, input int exp_lat, input int exp_slot, input string tag);
        int lat = 0;
        while (get_ready(d) !== 1'b1 && lat < exp_lat + 100) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " ready latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " nrs_slot"}, 64'(get_slot(d)), 64'(exp_slot));
    endtask

    task automatic wait_slot(input int d, input int exp_slot, input int maxc, input string tag);
        int c = 0;
        while (!(get_ready(d) === 1'b1 && get_slot(d) == 5'(exp_slot)) && c < maxc) begin
            @(negedge clk);
            c++;
        end
        check({tag, " slot became readable"}, 64'(c < maxc), 64'd1);
    endtask

    // Drive random (or one forced) address pair per cycle and queue the expected entries.
    task automatic read_burst(input int d, input logic [63:0] bits, input int n,
                              input int f0, input int f1);
        rd_item_t it;
        int depth, amax;
        depth = (d == 0) ? (N_SYM * A_BPS / 2) : (N_SYM * B_BPS / 2);
        amax  = (d == 0) ? 3 : 7;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (k == 0 && f0 >= 0) begin
                it.a0 = f0; it.a1 = f1;
            end else begin
                it.a0 = $urandom_range(0, amax);
                it.a1 = $urandom_range(0, amax);
            end
            if (d == 0) ifa.rd_addr = 4'((it.a1 << 2) | it.a0);
            else        ifb.rd_addr = 6'((it.a1 << 3) | it.a0);
            it.dut  = d;
            it.r[0] = (it.a0 < depth) ? bits[2*it.a0]     : 1'b0;
            it.i[0] = (it.a0 < depth) ? bits[2*it.a0 + 1] : 1'b0;
            it.r[1] = (it.a1 < depth) ? bits[2*it.a1]     : 1'b0;
            it.i[1] = (it.a1 < depth) ? bits[2*it.a1 + 1] : 1'b0;
            sb.push_back(it);
        end
    endtask

    // Monitor: one cycle after each address is presented, compare both ports.
    initial begin
        rd_item_t it;
        logic [1:0] ar, ai;
        forever begin
            @(posedge clk);
            #1;
            while (sb.size() != 0) begin
                it = sb.pop_front();
                ar = get_r(it.dut);
                ai = get_i(it.dut);
                check($sformatf("read dut%0d port0 addr%0d nrs_r", it.dut, it.a0), 64'(ar[0]), 64'(it.r[0]));
                check($sformatf("read dut%0d port0 addr%0d nrs_i", it.dut, it.a0), 64'(ai[0]), 64'(it.i[0]));
                check($sformatf("read dut%0d port1 addr%0d nrs_r", it.dut, it.a1), 64'(ar[1]), 64'(it.r[1]));
                check($sformatf("read dut%0d port1 addr%0d nrs_i", it.dut, it.a1), 64'(ai[1]), 64'(it.i[1]));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] bits;
        int n_id, es, wait_c;

        rst = 1'b1;
        ifa.new_frame = 1'b0; ifa.N_cell_ID = '0; ifa.est_ack = 1'b0; ifa.rd_addr = '0;
        ifb.new_frame = 1'b0; ifb.N_cell_ID = '0; ifb.est_ack = 1'b0; ifb.rd_addr = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset dut%0d nrs_ready", d), 64'(get_ready(d)), 64'd0);
            check($sformatf("reset dut%0d nrs_slot", d),  64'(get_slot(d)),  64'd0);
            check($sformatf("reset dut%0d busy", d),      64'(get_busy(d)),  64'd0);
            check($sformatf("reset dut%0d nrs_r", d),     64'(get_r(d)),     64'd0);
            check($sformatf("reset dut%0d nrs_i", d),     64'(get_i(d)),     64'd0);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle without new_frame busy", 64'(get_busy(0)), 64'd0);

        // Instance B: N_cell_ID=503 through all 20 slots (max cinit at slot 19) and the wrap.
        pulse_nf(1, 503);
        wait_ready(1, B_LAT, 0, "B slot0");
        bits = exp_bank(503, 0, B_BPS, B_SEQ, B_NC);
        read_burst(1, bits, 5, 0, 7);
        pulse_ack(1);
        check("B ack without swap clears nrs_ready", 64'(get_ready(1)), 64'd0);
        for (int s = 1; s <= 20; s++) begin
            es = s % 20;
            wait_slot(1, es, 400, $sformatf("B slot%0d", es));
            bits = exp_bank(503, es, B_BPS, B_SEQ, B_NC);
            read_burst(1, bits, 4, 6, es % 6);
            pulse_ack(1);
        end

        // Instance A: N_cell_ID=0, slot 0 timing and contents, concurrent port reads.
        pulse_nf(0, 0);
        wait_ready(0, A_LAT, 0, "A cell0 slot0");
        bits = exp_bank(0, 0, A_BPS, A_SEQ, A_NC);
        read_burst(0, bits, 6, 0, 3);
        check("A busy while generating slot1", 64'(get_busy(0)), 64'd1);

        // No ack: slot 1 completes and waits; slot 0 stays readable.
        wait_c = 0;
        while (get_busy(0) !== 1'b0 && wait_c < 4000) begin
            @(negedge clk);
            wait_c++;
        end
        check("A reaches WAIT_SWAP (busy low)", 64'(wait_c < 4000), 64'd1);
        repeat (10) @(negedge clk);
        check("A waiting busy", 64'(get_busy(0)), 64'd0);
        check("A waiting nrs_ready", 64'(get_ready(0)), 64'd1);
        check("A waiting nrs_slot", 64'(get_slot(0)), 64'd0);
        read_burst(0, bits, 4, -1, -1);
        pulse_ack(0);
        check("A swap on ack nrs_slot", 64'(get_slot(0)), 64'd1);
        check("A swap on ack nrs_ready", 64'(get_ready(0)), 64'd1);
        check("A swap on ack busy", 64'(get_busy(0)), 64'd1);
        bits = exp_bank(0, 1, A_BPS, A_SEQ, A_NC);
        read_burst(0, bits, 4, -1, -1);

        // new_frame during SKIP of the following slot: abort and restart at slot 0.
        repeat (300) @(negedge clk);
        check("A busy mid-SKIP", 64'(get_busy(0)), 64'd1);
        n_id = $urandom_range(1, 503);
        pulse_nf(0, n_id);
        check("A new_frame clears nrs_ready", 64'(get_ready(0)), 64'd0);
        wait_ready(0, A_LAT, 0, "A restart slot0");
        bits = exp_bank(n_id, 0, A_BPS, A_SEQ, A_NC);
        read_burst(0, bits, 5, -1, -1);

        // Reset in the middle of a CAPTURE run.
        n_id = $urandom_range(0, 503);
        pulse_nf(0, n_id);
        wait_ready(0, A_LAT, 0, "A pre-reset slot0");
        repeat (1828) @(negedge clk);
        check("A busy before reset", 64'(get_busy(0)), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("A async reset nrs_ready", 64'(get_ready(0)), 64'd0);
        check("A async reset busy",      64'(get_busy(0)),  64'd0);
        check("A async reset nrs_slot",  64'(get_slot(0)),  64'd0);
        check("A async reset nrs_r",     64'(get_r(0)),     64'd0);
        check("A async reset nrs_i",     64'(get_i(0)),     64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("A idle after reset busy", 64'(get_busy(0)), 64'd0);
        check("A idle after reset nrs_ready", 64'(get_ready(0)), 64'd0);
        n_id = $urandom_range(0, 503);
        pulse_nf(0, n_id);
        wait_ready(0, A_LAT, 0, "A post-reset slot0");
        bits = exp_bank(n_id, 0, A_BPS, A_SEQ, A_NC);
        read_burst(0, bits, 5, 3, 0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
